hex_message_scroller: RTL

// Upstream content source for seven_segment_display: stores a hex message of up to MSG_DEPTH

---
 rtl/hex_message_scroller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hex_message_scroller.sv
// Hex message store and scroller: holds up to MSG_DEPTH nibbles (each with a dot) and scrolls
// them leftward across a W_DIGITS-digit window in seven_segment_display packed format.
module hex_message_scroller #(
  parameter int W_DIGITS    = 8,
  parameter int MSG_DEPTH   = 32,
  parameter int W_DIV       = 22,
  parameter int PAUSE_TICKS = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [3:0]            wr_nibble_i,
  input  logic                  wr_dot_i,
  input  logic                  wr_last_i,
  output logic [W_DIGITS*4-1:0] number_o,
  output logic [W_DIGITS-1:0]   dots_o,
  output logic                  busy_o,
  output logic                  wrap_pulse_o
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(PAUSE_TICKS + 1);

  typedef enum logic [1:0] {EMPTY, LOAD, PAUSE, SCROLL} state_t;

  state_t                state_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         offset_q;
  logic [LW-1:0]         len_q;
  logic [W_DIV-1:0]      div_q;
  logic [PW-1:0]         pause_q;
  logic [W_DIGITS*4-1:0] number_q;
  logic [W_DIGITS-1:0]   dots_q;
  logic                  wrap_q;

  logic [3:0]            msg_nib [MSG_DEPTH];
  logic                  msg_dot [MSG_DEPTH];

  logic                  active;
  logic                  tick;
  logic                  accept;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         last_idx;
  logic [AW-1:0]         idx;
  logic [W_DIGITS*4-1:0] number_d;
  logic [W_DIGITS-1:0]   dots_d;

  assign active     = (state_q == PAUSE) || (state_q == SCROLL);
  assign tick       = active && run_i && (div_q == '1);
  assign wr_ready_o = (state_q == EMPTY) || (state_q == LOAD);
  assign accept     = wr_valid_i && wr_ready_o;
  assign wr_addr    = (state_q == EMPTY) ? '0 : wr_ptr_q;
  assign last_idx   = AW'(len_q - 1'b1);

  assign number_o     = number_q;
  assign dots_o       = dots_q;
  assign wrap_pulse_o = wrap_q;
  assign busy_o       = (state_q != EMPTY);

  // Message RAM needs no reset; a cleared or reset cycle must not store the beat.
  always_ff @(posedge clock_i) begin
    if (accept && !reset_i && !clear_i) begin
      msg_nib[wr_addr] <= wr_nibble_i;
      msg_dot[wr_addr] <= wr_dot_i;
    end
  end

  // Walk the window left to right, wrapping at len-1 so any len repeats cyclically.
  always_comb begin
    number_d = '0;
    dots_d   = '0;
    idx      = offset_q;
    if (active) begin
      for (int k = 0; k < W_DIGITS; k++) begin
        number_d[(W_DIGITS-1-k)*4 +: 4] = msg_nib[idx];
        dots_d[W_DIGITS-1-k]            = msg_dot[idx];
        idx = (idx == last_idx) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      offset_q <= '0;
      len_q    <= '0;
      div_q    <= '0;
      pause_q  <= '0;
      number_q <= '0;
      dots_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      number_q <= number_d;
      dots_q   <= dots_d;
      wrap_q   <= 1'b0;
      if (active && run_i) begin
        div_q <= div_q + 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            wr_ptr_q <= AW'(1);
            offset_q <= '0;
            if (wr_last_i) begin
              len_q   <= LW'(1);
              div_q   <= '0;
              pause_q <= '0;
              state_q <= PAUSE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_last_i || (wr_ptr_q == AW'(MSG_DEPTH - 1))) begin
              len_q    <= {1'b0, wr_ptr_q} + 1'b1;
              offset_q <= '0;
              div_q    <= '0;
              pause_q  <= '0;
              state_q  <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (tick) begin
            if (pause_q == PW'(PAUSE_TICKS - 1)) begin
              pause_q <= '0;
              state_q <= SCROLL;
            end else begin
              pause_q <= pause_q + 1'b1;
            end
          end
        end
        SCROLL: begin
          if (tick) begin
            if (offset_q == last_idx) begin
              offset_q <= '0;
              wrap_q   <= 1'b1;
              state_q  <= PAUSE;
            end else begin
              offset_q <= offset_q + 1'b1;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
